line_check_sched: RTL and testbench

//  Time-multiplexes one external LineCheck datapath across a table of up to MAX_SEG line segments.
//  Per accepted pixel, walks segments 0..N-1, drives the pixel and segment vertices to LineCheck,

---
 rtl/line_check_sched_if.sv | 42 ++++
 rtl/line_check_sched.sv | 155 +++++++++++++++
 tb/tb_line_check_sched.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/line_check_sched_if.sv
// Pixel request, LineCheck drive/return and result handshake between the
// scheduler and its surroundings.
//   master : system side (pixel source, LineCheck result, result consumer)
//   slave  : line_check_sched
// Signals: pix_valid/pix_ready, h_cnt_Q/v_cnt_Q (pixel in),
//          chk_* (pixel + segment vertices out, chk_onLine back),
//          res_valid/res_ready, res_hit, res_seg (result out).
interface line_check_sched_if #(
    parameter int unsigned IDX_W = 3
);
    logic                    pix_valid;
    logic                    pix_ready;
    logic signed [15:0]      h_cnt_Q;
    logic signed [15:0]      v_cnt_Q;

    logic signed [15:0]      chk_h_cnt_Q;
    logic signed [15:0]      chk_v_cnt_Q;
    logic signed [15:0]      chk_vtxA_X;
    logic signed [15:0]      chk_vtxA_Y;
    logic signed [15:0]      chk_vtxB_X;
    logic signed [15:0]      chk_vtxB_Y;
    logic                    chk_onLine;

    logic                    res_valid;
    logic                    res_ready;
    logic                    res_hit;
    logic [IDX_W-1:0]        res_seg;

    modport master (
        output pix_valid, h_cnt_Q, v_cnt_Q, chk_onLine, res_ready,
        input  pix_ready, chk_h_cnt_Q, chk_v_cnt_Q,
               chk_vtxA_X, chk_vtxA_Y, chk_vtxB_X, chk_vtxB_Y,
               res_valid, res_hit, res_seg
    );

    modport slave (
        input  pix_valid, h_cnt_Q, v_cnt_Q, chk_onLine, res_ready,
        output pix_ready, chk_h_cnt_Q, chk_v_cnt_Q,
               chk_vtxA_X, chk_vtxA_Y, chk_vtxB_X, chk_vtxB_Y,
               res_valid, res_hit, res_seg
    );
endinterface

// File: rtl/line_check_sched.sv
// Time-multiplexes one external LineCheck datapath across a table of up to
// MAX_SEG line segments. Each accepted pixel is checked against segments
// 0..N-1 and one hit/miss result with the lowest hitting index is returned.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_we/cfg_idx    segment table write (ignored while cfg_busy)
//   cfg_vtxA/B_X/Y    vertices of the written entry
//   cfg_busy          scheduler not idle
//   seg_count         active segment count, sampled at pixel accept
//   bus (slave)       pixel request, LineCheck drive/return, result
// Build option: define LINE_SCHED_EARLY_EXIT_EN to finish the scan on the
// first hit instead of always walking all N entries.
module line_check_sched #(
    parameter int unsigned MAX_SEG = 8,
    parameter int unsigned IDX_W   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic signed [15:0]  cfg_vtxA_X,
    input  logic signed [15:0]  cfg_vtxA_Y,
    input  logic signed [15:0]  cfg_vtxB_X,
    input  logic signed [15:0]  cfg_vtxB_Y,
    output logic                cfg_busy,
    input  logic [IDX_W:0]      seg_count,
    line_check_sched_if.slave   bus
);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic signed [15:0] ax;
        logic signed [15:0] ay;
        logic signed [15:0] bx;
        logic signed [15:0] by;
    } seg_t;

    seg_t               r_tab [MAX_SEG];
    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_n;
    logic signed [15:0] r_pix_x;
    logic signed [15:0] r_pix_y;
    logic               r_pix_ready;
    logic               r_cfg_busy;
    logic               r_res_valid;
    logic               r_res_hit;
    logic [IDX_W-1:0]   r_res_seg;

    logic [CNT_W-1:0]   w_n_acc;
    logic               w_last;
    logic               w_stop;

    // Clamp the requested segment count to the table depth.
    assign w_n_acc = (seg_count > CNT_W'(MAX_SEG)) ? CNT_W'(MAX_SEG) : seg_count;
    assign w_last  = ({1'b0, r_idx} == (r_n - CNT_W'(1)));

`ifdef LINE_SCHED_EARLY_EXIT_EN
    assign w_stop = w_last || bus.chk_onLine;
`else
    assign w_stop = w_last;
`endif

    // Segment table; writes only land while the scheduler is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MAX_SEG); i++) begin
                r_tab[i] <= '0;
            end
        end else if (cfg_we && !r_cfg_busy) begin
            r_tab[cfg_idx] <= {cfg_vtxA_X, cfg_vtxA_Y, cfg_vtxB_X, cfg_vtxB_Y};
        end
    end

    // Scheduler FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_n         <= '0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_pix_ready <= 1'b0;
            r_cfg_busy  <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_hit   <= 1'b0;
            r_res_seg   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.pix_valid && r_pix_ready) begin
                        r_pix_x     <= bus.h_cnt_Q;
                        r_pix_y     <= bus.v_cnt_Q;
                        r_n         <= w_n_acc;
                        r_idx       <= '0;
                        r_res_hit   <= 1'b0;
                        r_res_seg   <= '0;
                        r_pix_ready <= 1'b0;
                        r_cfg_busy  <= 1'b1;
                        if (w_n_acc == '0) begin
                            r_state     <= ST_DONE;
                            r_res_valid <= 1'b1;
                        end else begin
                            r_state <= ST_SCAN;
                        end
                    end else begin
                        r_pix_ready <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    // Only the first hit is kept, giving the lowest index.
                    if (bus.chk_onLine && !r_res_hit) begin
                        r_res_hit <= 1'b1;
                        r_res_seg <= r_idx;
                    end
                    if (w_stop) begin
                        r_state     <= ST_DONE;
                        r_res_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        r_state     <= ST_IDLE;
                        r_res_valid <= 1'b0;
                        r_pix_ready <= 1'b1;
                        r_cfg_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_busy        = r_cfg_busy;
    assign bus.pix_ready   = r_pix_ready;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_hit     = r_res_hit;
    assign bus.res_seg     = r_res_seg;
    assign bus.chk_h_cnt_Q = r_pix_x;
    assign bus.chk_v_cnt_Q = r_pix_y;
    assign bus.chk_vtxA_X  = r_tab[r_idx].ax;
    assign bus.chk_vtxA_Y  = r_tab[r_idx].ay;
    assign bus.chk_vtxB_X  = r_tab[r_idx].bx;
    assign bus.chk_vtxB_Y  = r_tab[r_idx].by;
endmodule

// File: tb/tb_line_check_sched.sv
// Self-checking bench for line_check_sched with a behavioural LineCheck
// (bounding box plus cross-product tolerance) on the chk_* bus.
module tb_line_check_sched;
    localparam int unsigned MAX_SEG = 8;
    localparam int unsigned IDX_W   = 3;
`ifdef LINE_SCHED_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cfg_we;
    logic [IDX_W-1:0]   cfg_idx;
    logic signed [15:0] cfg_vtxA_X, cfg_vtxA_Y, cfg_vtxB_X, cfg_vtxB_Y;
    logic               cfg_busy;
    logic [IDX_W:0]     seg_count;

    line_check_sched_if #(.IDX_W(IDX_W)) bus ();

    line_check_sched #(.MAX_SEG(MAX_SEG), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_vtxA_X (cfg_vtxA_X),
        .cfg_vtxA_Y (cfg_vtxA_Y),
        .cfg_vtxB_X (cfg_vtxB_X),
        .cfg_vtxB_Y (cfg_vtxB_Y),
        .cfg_busy   (cfg_busy),
        .seg_count  (seg_count),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // LineCheck: pixel inside the segment box and |cross >>> 5| <= 2.
    logic signed [31:0] lc_dx, lc_dy, lc_rx, lc_ry, lc_cross, lc_sc;
    logic lc_inx, lc_iny;
    always_comb begin
        lc_dx    = 32'(bus.chk_vtxB_X) - 32'(bus.chk_vtxA_X);
        lc_dy    = 32'(bus.chk_vtxB_Y) - 32'(bus.chk_vtxA_Y);
        lc_rx    = 32'(bus.chk_h_cnt_Q) - 32'(bus.chk_vtxA_X);
        lc_ry    = 32'(bus.chk_v_cnt_Q) - 32'(bus.chk_vtxA_Y);
        lc_cross = lc_dx * lc_ry - lc_dy * lc_rx;
        lc_sc    = lc_cross >>> 5;
        lc_inx   = (bus.chk_h_cnt_Q >= bus.chk_vtxA_X && bus.chk_h_cnt_Q <= bus.chk_vtxB_X) ||
                   (bus.chk_h_cnt_Q >= bus.chk_vtxB_X && bus.chk_h_cnt_Q <= bus.chk_vtxA_X);
        lc_iny   = (bus.chk_v_cnt_Q >= bus.chk_vtxA_Y && bus.chk_v_cnt_Q <= bus.chk_vtxB_Y) ||
                   (bus.chk_v_cnt_Q >= bus.chk_vtxB_Y && bus.chk_v_cnt_Q <= bus.chk_vtxA_Y);
        bus.chk_onLine = lc_inx && lc_iny && (lc_sc >= -32'sd2) && (lc_sc <= 32'sd2);
    end

    typedef struct {
        string name;
        int    segc;
        int    px;
        int    py;
        int    hit;
        int    seg;
        int    lat_full;
        int    lat_early;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input string nm, input int segc, input int px, input int py,
                           input int hit, input int seg, input int lf, input int le);
        vec_t v;
        v.name = nm; v.segc = segc; v.px = px; v.py = py;
        v.hit = hit; v.seg = seg; v.lat_full = lf; v.lat_early = le;
        vq.push_back(v);
    endtask

    task automatic cfg_write(input int idx, input int ax, input int ay, input int bx, input int by);
        @(negedge clk);
        cfg_we     = 1'b1;
        cfg_idx    = IDX_W'(idx);
        cfg_vtxA_X = 16'(ax);
        cfg_vtxA_Y = 16'(ay);
        cfg_vtxB_X = 16'(bx);
        cfg_vtxB_Y = 16'(by);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    // Returns at a negedge with pix_ready high (or after a bounded wait).
    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!bus.pix_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) check("ready_timeout", 0, 1);
    endtask

    // Offers one pixel, then counts cycles after accept until res_valid.
    // seg_count is changed right after accept to show it is latched.
    task automatic run_pix(input int segc, input int px, input int py,
                           output int lat, output int hit, output int seg,
                           output int h1, output int rdy1);
        wait_ready();
        bus.pix_valid = 1'b1;
        bus.h_cnt_Q   = 16'(px);
        bus.v_cnt_Q   = 16'(py);
        seg_count     = 4'(segc);
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
        seg_count     = 4'd0;
        h1   = int'(bus.chk_h_cnt_Q);
        rdy1 = int'(bus.pix_ready);
        lat  = 1;
        while (!bus.res_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        hit = int'(bus.res_hit);
        seg = int'(bus.res_seg);
    endtask

    task automatic release_res(input string nm);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        check({nm, "_valid_drop"}, int'(bus.res_valid), 0);
        check({nm, "_ready_back"}, int'(bus.pix_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, hit, seg, h1, rdy1;

        rst_n = 1'b0;
        cfg_we = 1'b0; cfg_idx = '0;
        cfg_vtxA_X = '0; cfg_vtxA_Y = '0; cfg_vtxB_X = '0; cfg_vtxB_Y = '0;
        seg_count = '0;
        bus.pix_valid = 1'b0; bus.h_cnt_Q = '0; bus.v_cnt_Q = '0; bus.res_ready = 1'b0;

        // Reset values
        #22;
        check("rst_pix_ready", int'(bus.pix_ready), 0);
        check("rst_cfg_busy",  int'(cfg_busy), 0);
        check("rst_res_valid", int'(bus.res_valid), 0);
        check("rst_chk_vtxB_X", int'(bus.chk_vtxB_X), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_pix_ready", int'(bus.pix_ready), 1);

        // Table setup; entry 0 visible on chk_* (idx=0) the next cycle
        cfg_write(0, 0, 0, 100, 100);
        check("wr_visible_B_X", int'(bus.chk_vtxB_X), 100);
        check("wr_visible_B_Y", int'(bus.chk_vtxB_Y), 100);
        cfg_write(2, 0, 10, 200, 10);
        cfg_write(5, 100, 10, 300, 10);

        add_vec("n1_on",     1,  50,  50, 1, 0, 2, 2);
        add_vec("n1_off",    1,  50,  70, 0, 0, 2, 2);
        add_vec("n4_seg2",   4,  30,  10, 1, 2, 5, 4);
        add_vec("n0",        0,   7,   7, 0, 0, 1, 1);
        add_vec("n15_miss", 15, 500, 500, 0, 0, 9, 9);
        add_vec("n15_seg2", 15,  30,  10, 1, 2, 9, 4);
        add_vec("n4_seg0",   4,  50,  50, 1, 0, 5, 2);
        add_vec("n3_both",   3,  10,  10, 1, 0, 4, 2);
        add_vec("n8_low",    8, 150,  10, 1, 2, 9, 4);
        add_vec("n2_miss",   2,  30,  10, 0, 0, 3, 3);

        foreach (vq[i]) begin
            run_pix(vq[i].segc, vq[i].px, vq[i].py, lat, hit, seg, h1, rdy1);
            check({vq[i].name, "_lat"}, lat, EARLY ? vq[i].lat_early : vq[i].lat_full);
            check({vq[i].name, "_hit"}, hit, vq[i].hit);
            check({vq[i].name, "_seg"}, seg, vq[i].seg);
            check({vq[i].name, "_latched_x"}, h1, vq[i].px);
            check({vq[i].name, "_busy_ready"}, rdy1, 0);
            release_res(vq[i].name);
        end

        // Consumer stall in DONE with a config write attempt
        run_pix(4, 30, 10, lat, hit, seg, h1, rdy1);
        check("stall_first_seg", seg, 2);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                @(negedge clk);
                check("stall_cfg_busy", int'(cfg_busy), 1);
                cfg_we = 1'b1; cfg_idx = 3'd2;
                cfg_vtxA_X = '0; cfg_vtxA_Y = '0; cfg_vtxB_X = '0; cfg_vtxB_Y = '0;
            end
            @(posedge clk);
            #1;
            cfg_we = 1'b0;
            check("stall_valid", int'(bus.res_valid), 1);
            check("stall_hit",   int'(bus.res_hit), 1);
            check("stall_seg",   int'(bus.res_seg), 2);
            check("stall_ready", int'(bus.pix_ready), 0);
        end
        release_res("stall");
        run_pix(4, 30, 10, lat, hit, seg, h1, rdy1);
        check("drop_wr_hit", hit, 1);
        check("drop_wr_seg", seg, 2);
        release_res("drop_wr");

        // Reset while the scan sits at idx=3
        wait_ready();
        bus.pix_valid = 1'b1; bus.h_cnt_Q = 16'sd30; bus.v_cnt_Q = 16'sd10; seg_count = 4'd8;
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",      int'(cfg_busy), 0);
        check("mid_rst_pix_ready", int'(bus.pix_ready), 0);
        check("mid_rst_valid",     int'(bus.res_valid), 0);
        check("mid_rst_hit",       int'(bus.res_hit), 0);
        check("mid_rst_seg",       int'(bus.res_seg), 0);
        check("mid_rst_chk_x",     int'(bus.chk_h_cnt_Q), 0);
        check("mid_rst_vtxA_Y",    int'(bus.chk_vtxA_Y), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready",  int'(bus.pix_ready), 1);
        check("post_rst_tab_BX", int'(bus.chk_vtxB_X), 0);
        run_pix(1, 50, 50, lat, hit, seg, h1, rdy1);
        check("post_rst_lat", lat, 2);
        check("post_rst_hit", hit, 0);
        release_res("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
